// File: rtl/io_target_pkg.sv
// Shared types for the io_target I/O port decoder: device FSM state encoding
// and the posted-write buffer entry.
package io_target_pkg;

    localparam int OFF_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_ACK,
        RD_REQ,
        RD_ACK,
        RD_DONE
    } dev_state_e;

    typedef struct packed {
        logic [OFF_W-1:0] offset;
        logic [31:0]      data;
        logic [2:0]       n;
    } wb_entry_t;

    // Bytes to move: a whole word for aligned 32-bit accesses, otherwise the
    // remaining count clamped into 1..4 so a bad size can never stall the FSM.
    function automatic logic [2:0] xfer_len(input logic wide, input logic [2:0] size);
        if (wide)         return 3'd4;
        if (size == 3'd0) return 3'd1;
        if (size > 3'd4)  return 3'd4;
        return size;
    endfunction

endpackage

// File: rtl/io_target_wbuf.sv
// Posted-write buffer: synchronous FIFO of wb_entry_t with full/empty flags
// and an occupancy count.
module io_target_wbuf
    import io_target_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  wb_entry_t                push_data,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/io_target.sv
// I/O port target: decodes a window of ports, posts writes through a small
// buffer and serialises every access into single-byte device requests.
module io_target
    import io_target_pkg::*;
#(
    parameter logic [15:0] BASE      = 16'h0000,
    parameter int          SPAN_LOG2 = 3,
    parameter bit          IO32      = 1'b0,
    parameter int          WB_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [15:0]          bus_address,
    input  logic                 bus_read,
    input  logic                 bus_write,
    input  logic [2:0]           bus_datasize,
    input  logic [31:0]          bus_writedata,
    output logic [31:0]          bus_readdata,
    output logic                 bus_io32,
    output logic                 io_wait,
    output logic                 dev_req,
    output logic                 dev_we,
    output logic [SPAN_LOG2-1:0] dev_addr,
    output logic [7:0]           dev_wdata,
    input  logic [7:0]           dev_rdata,
    input  logic                 dev_ack
);
    localparam int          CNT_W = $clog2(WB_DEPTH) + 1;
    localparam logic [16:0] LIMIT = {1'b0, BASE} + (17'd1 << SPAN_LOG2);

    dev_state_e           state_q, state_d;
    logic [2:0]           k_q, k_d, k_nx;
    logic                 wait_q, wait_d, rd_pend_q, rd_pend_d, hold_v_q, hold_v_d;
    logic [15:0]          rd_off_q, rd_off_d, hold_addr_q, hold_addr_d;
    logic [2:0]           rd_n_q, rd_n_d, hold_size_q, hold_size_d;
    logic [31:0]          hold_data_q, hold_data_d, rbuf_q, rbuf_d, rdata_q, rdata_d;
    logic                 dev_req_q, dev_req_d, dev_we_q, dev_we_d;
    logic [SPAN_LOG2-1:0] dev_addr_q, dev_addr_d;
    logic [7:0]           dev_wdata_q, dev_wdata_d;
    logic                 hit, wr_hit, rd_hit, hold_wide;
    logic [15:0]          offset, hold_off;
    logic                 wb_push, wb_pop, wb_full, wb_empty;
    logic [CNT_W-1:0]     wb_count;
    wb_entry_t            wb_in, wb_head;

    assign hit       = ({1'b0, bus_address} >= {1'b0, BASE}) && ({1'b0, bus_address} < LIMIT);
    assign offset    = bus_address - BASE;
    assign bus_io32  = hit && IO32 && (bus_address[1:0] == 2'b00);
    // Strobes that arrive while stalled are protocol errors and are dropped.
    assign wr_hit    = bus_write && hit && !wait_q;
    assign rd_hit    = bus_read && hit && !wait_q && !wr_hit;
    assign io_wait   = wait_q || (wr_hit && wb_full);
    assign hold_off  = hold_addr_q - BASE;
    assign hold_wide = IO32 && (hold_addr_q[1:0] == 2'b00);

    io_target_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (wb_push),
        .push_data (wb_in),
        .pop       (wb_pop),
        .head      (wb_head),
        .full      (wb_full),
        .empty     (wb_empty),
        .count     (wb_count)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        k_nx        = k_q + 3'd1;
        wait_d      = wait_q;
        rd_pend_d   = rd_pend_q;
        rd_off_d    = rd_off_q;
        rd_n_d      = rd_n_q;
        hold_v_d    = hold_v_q;
        hold_addr_d = hold_addr_q;
        hold_size_d = hold_size_q;
        hold_data_d = hold_data_q;
        rbuf_d      = rbuf_q;
        rdata_d     = rdata_q;
        dev_req_d   = 1'b0;
        dev_we_d    = dev_we_q;
        dev_addr_d  = dev_addr_q;
        dev_wdata_d = dev_wdata_q;
        wb_push     = 1'b0;
        wb_pop      = 1'b0;
        wb_in       = '0;

        if (hold_v_q && (wb_count < CNT_W'(WB_DEPTH))) begin
            wb_push      = 1'b1;
            wb_in.offset = hold_off;
            wb_in.data   = hold_data_q;
            wb_in.n      = xfer_len(hold_wide, hold_size_q);
            hold_v_d     = 1'b0;
            wait_d       = 1'b0;
        end else if (wr_hit && wb_full) begin
            hold_v_d     = 1'b1;
            wait_d       = 1'b1;
            hold_addr_d  = bus_address;
            hold_size_d  = bus_datasize;
            hold_data_d  = bus_writedata;
        end else if (wr_hit) begin
            wb_push      = 1'b1;
            wb_in.offset = offset;
            wb_in.data   = bus_writedata;
            wb_in.n      = xfer_len(bus_io32, 3'd1);
        end else if (rd_hit) begin
            wait_d       = 1'b1;
            rd_pend_d    = 1'b1;
            rd_off_d     = offset;
            rd_n_d       = xfer_len(bus_io32, bus_datasize);
            rbuf_d       = '0;
        end

        // Requests are registered on entry to *_REQ, so dev_req is high
        // exactly while the FSM sits in that state.
        case (state_q)
            IDLE: begin
                if (rd_pend_q && wb_empty) begin
                    state_d    = RD_REQ;
                    k_d        = 3'd0;
                    dev_req_d  = 1'b1;
                    dev_we_d   = 1'b0;
                    dev_addr_d = rd_off_q[SPAN_LOG2-1:0];
                end else if (!wb_empty) begin
                    state_d     = WR_REQ;
                    k_d         = 3'd0;
                    dev_req_d   = 1'b1;
                    dev_we_d    = 1'b1;
                    dev_addr_d  = wb_head.offset[SPAN_LOG2-1:0];
                    dev_wdata_d = wb_head.data[7:0];
                end
            end
            WR_REQ: state_d = WR_ACK;
            WR_ACK: begin
                if (dev_ack) begin
                    k_d = k_nx;
                    if (k_nx == wb_head.n) begin
                        wb_pop  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d     = WR_REQ;
                        dev_req_d   = 1'b1;
                        dev_addr_d  = SPAN_LOG2'(wb_head.offset + 16'(k_nx));
                        dev_wdata_d = wb_head.data[{k_nx[1:0], 3'b000} +: 8];
                    end
                end
            end
            RD_REQ: state_d = RD_ACK;
            RD_ACK: begin
                if (dev_ack) begin
                    rbuf_d[{k_q[1:0], 3'b000} +: 8] = dev_rdata;
                    k_d = k_nx;
                    if (k_nx == rd_n_q) begin
                        state_d = RD_DONE;
                    end else begin
                        state_d    = RD_REQ;
                        dev_req_d  = 1'b1;
                        dev_addr_d = SPAN_LOG2'(rd_off_q + 16'(k_nx));
                    end
                end
            end
            RD_DONE: begin
                rdata_d   = rbuf_q;
                wait_d    = 1'b0;
                rd_pend_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            wait_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            hold_v_q    <= 1'b0;
            rdata_q     <= '0;
            dev_req_q   <= 1'b0;
            dev_we_q    <= 1'b0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wait_q      <= wait_d;
            rd_pend_q   <= rd_pend_d;
            hold_v_q    <= hold_v_d;
            rdata_q     <= rdata_d;
            dev_req_q   <= dev_req_d;
            dev_we_q    <= dev_we_d;
            dev_addr_q  <= dev_addr_d;
            dev_wdata_q <= dev_wdata_d;
        end
    end

    // Payload registers are only meaningful while their valid/pending flag is set.
    always_ff @(posedge clk) begin
        rd_off_q    <= rd_off_d;
        rd_n_q      <= rd_n_d;
        hold_addr_q <= hold_addr_d;
        hold_size_q <= hold_size_d;
        hold_data_q <= hold_data_d;
        rbuf_q      <= rbuf_d;
    end

    assign bus_readdata = rdata_q;
    assign dev_req      = dev_req_q;
    assign dev_we       = dev_we_q;
    assign dev_addr     = dev_addr_q;
    assign dev_wdata    = dev_wdata_q;

endmodule

// File: tb/tb_io_target.sv
// Directed bench for io_target: two instances (byte-only and 32-bit capable)
// with simple device responders that log every request.
module tb_io_target;

    logic        clk;
    logic        reset_n;
    logic [15:0] bus_address;
    logic        bus_read, bus_write;
    logic [2:0]  bus_datasize;
    logic [31:0] bus_writedata;
    logic [31:0] bus_readdata;
    logic        bus_io32, io_wait;
    logic        dev_req, dev_we, dev_ack;
    logic [2:0]  dev_addr;
    logic [7:0]  dev_wdata, dev_rdata;

    logic        b1_read, b1_write;
    logic [31:0] b1_readdata;
    logic        b1_io32, b1_wait;
    logic        d1_req, d1_we, d1_ack;
    logic [2:0]  d1_addr;
    logic [7:0]  d1_wdata, d1_rdata;

    int total = 0;
    int bad   = 0;

    logic       ack_en;
    logic [7:0] rdq[$];
    logic       pend0, pend_we0, pend1;
    int         n_log0 = 0, n_log1 = 0;
    logic       log_we0   [64];
    logic [2:0] log_addr0 [64];
    logic [7:0] log_data0 [64];
    logic [2:0] log_addr1 [64];
    logic [7:0] log_data1 [64];
    int         base, base1;
    logic [31:0] w32;

    io_target #(.BASE(16'h0060), .SPAN_LOG2(3), .IO32(1'b0), .WB_DEPTH(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus_address(bus_address), .bus_read(bus_read),
        .bus_write(bus_write), .bus_datasize(bus_datasize), .bus_writedata(bus_writedata),
        .bus_readdata(bus_readdata), .bus_io32(bus_io32), .io_wait(io_wait),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_rdata(dev_rdata), .dev_ack(dev_ack)
    );

    io_target #(.BASE(16'h0060), .SPAN_LOG2(3), .IO32(1'b1), .WB_DEPTH(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus_address(bus_address), .bus_read(b1_read),
        .bus_write(b1_write), .bus_datasize(bus_datasize), .bus_writedata(bus_writedata),
        .bus_readdata(b1_readdata), .bus_io32(b1_io32), .io_wait(b1_wait),
        .dev_req(d1_req), .dev_we(d1_we), .dev_addr(d1_addr), .dev_wdata(d1_wdata),
        .dev_rdata(d1_rdata), .dev_ack(d1_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Device 0: logs each request, acks one cycle later when ack_en allows.
    initial begin
        dev_ack = 1'b0; dev_rdata = 8'h00; pend0 = 1'b0; pend_we0 = 1'b0;
        forever begin
            @(negedge clk);
            dev_ack = 1'b0;
            if (pend0 && ack_en) begin
                dev_ack = 1'b1;
                dev_rdata = 8'h00;
                if (!pend_we0 && rdq.size() > 0) dev_rdata = rdq.pop_front();
                pend0 = 1'b0;
            end else if (dev_req === 1'b1 && n_log0 < 64) begin
                log_we0[n_log0]   = dev_we;
                log_addr0[n_log0] = dev_addr;
                log_data0[n_log0] = dev_wdata;
                n_log0++;
                pend0    = 1'b1;
                pend_we0 = dev_we;
            end
        end
    end

    // Device 1: always acks the cycle after a request.
    initial begin
        d1_ack = 1'b0; d1_rdata = 8'h00; pend1 = 1'b0;
        forever begin
            @(negedge clk);
            d1_ack = 1'b0;
            if (pend1) begin
                d1_ack = 1'b1;
                pend1  = 1'b0;
            end else if (d1_req === 1'b1 && n_log1 < 64) begin
                log_addr1[n_log1] = d1_addr;
                log_data1[n_log1] = d1_wdata;
                n_log1++;
                pend1 = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_log0(input int n);
        int c;
        c = 0;
        while (n_log0 < n && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("log0_count", 32'(n_log0), 32'(n));
    endtask

    task automatic wait_ready(input string tag);
        int c;
        c = 0;
        while (io_wait === 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 32'(io_wait), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; bus_address = 16'h0; bus_read = 1'b0; bus_write = 1'b0;
        bus_datasize = 3'd0; bus_writedata = 32'h0; b1_read = 1'b0; b1_write = 1'b0;
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_io_wait",   32'(io_wait),   32'd0);
        chk("rst_dev_req",   32'(dev_req),   32'd0);
        chk("rst_dev_we",    32'(dev_we),    32'd0);
        chk("rst_dev_addr",  32'(dev_addr),  32'd0);
        chk("rst_dev_wdata", 32'(dev_wdata), 32'd0);
        chk("rst_readdata",  bus_readdata,   32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single byte write at the window base.
        base = n_log0;
        @(negedge clk);
        bus_address = 16'h0060; bus_datasize = 3'd1; bus_writedata = 32'h0000_00A5; bus_write = 1'b1;
        #1;
        chk("w60_wait", 32'(io_wait), 32'd0);
        chk("w60_io32", 32'(bus_io32), 32'd0);
        @(negedge clk);
        bus_write = 1'b0;
        wait_log0(base + 1);
        chk("w60_we",   32'(log_we0[base]),   32'd1);
        chk("w60_addr", 32'(log_addr0[base]), 32'd0);
        chk("w60_data", 32'(log_data0[base]), 32'h0000_00A5);
        repeat (4) @(negedge clk);

        // Accesses just outside the window are ignored.
        base = n_log0;
        @(negedge clk);
        bus_address = 16'h0068; bus_write = 1'b1;
        #1 chk("miss68_wait", 32'(io_wait), 32'd0);
        @(negedge clk);
        bus_write = 1'b0; bus_address = 16'h005F; bus_read = 1'b1;
        #1 chk("miss5f_wait", 32'(io_wait), 32'd0);
        @(negedge clk);
        bus_read = 1'b0;
        #1 chk("miss5f_wait_after", 32'(io_wait), 32'd0);
        repeat (5) @(negedge clk);
        chk("miss_no_dev", 32'(n_log0), 32'(base));
        chk("miss_readdata", bus_readdata, 32'd0);

        // Fill the buffer with acks held off; the fifth write must stall.
        ack_en = 1'b0;
        base = n_log0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_address = 16'h0060 + 16'(i); bus_datasize = 3'd1;
            bus_writedata = 32'h10 + 32'(i); bus_write = 1'b1;
            #1 chk($sformatf("fill_wait%0d", i), 32'(io_wait), (i == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        bus_write = 1'b0;
        #1 chk("hold_wait", 32'(io_wait), 32'd1);
        ack_en = 1'b1;
        wait_log0(base + 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill_addr%0d", i), 32'(log_addr0[base+i]), 32'(i));
            chk($sformatf("fill_data%0d", i), 32'(log_data0[base+i]), 32'h10 + 32'(i));
        end
        wait_ready("fill_release");
        repeat (4) @(negedge clk);

        // Write then read the same port: the read waits for the write to drain.
        base = n_log0;
        rdq.push_back(8'h5A); rdq.push_back(8'h3C);
        @(negedge clk);
        bus_address = 16'h0061; bus_datasize = 3'd1; bus_writedata = 32'h0000_0077; bus_write = 1'b1;
        @(negedge clk);
        bus_write = 1'b0; bus_read = 1'b1; bus_datasize = 3'd2;
        #1 chk("rd61_strobe_wait", 32'(io_wait), 32'd0);
        @(negedge clk);
        bus_read = 1'b0;
        #1 chk("rd61_wait", 32'(io_wait), 32'd1);
        wait_ready("rd61_done");
        chk("rd61_data", bus_readdata, 32'h0000_3C5A);
        chk("rd61_ord_we0",  32'(log_we0[base]),     32'd1);
        chk("rd61_ord_a0",   32'(log_addr0[base]),   32'd1);
        chk("rd61_ord_we1",  32'(log_we0[base+1]),   32'd0);
        chk("rd61_ord_a1",   32'(log_addr0[base+1]), 32'd1);
        chk("rd61_ord_a2",   32'(log_addr0[base+2]), 32'd2);
        @(negedge clk);
        chk("rd61_hold", bus_readdata, 32'h0000_3C5A);

        // Read wrapping past the top of the window.
        base = n_log0;
        rdq.push_back(8'hC3); rdq.push_back(8'h96);
        @(negedge clk);
        bus_address = 16'h0067; bus_datasize = 3'd2; bus_read = 1'b1;
        @(negedge clk);
        bus_read = 1'b0;
        wait_ready("rd67_done");
        chk("rd67_a0", 32'(log_addr0[base]),   32'd7);
        chk("rd67_a1", 32'(log_addr0[base+1]), 32'd0);
        chk("rd67_data", bus_readdata, 32'h0000_96C3);

        // A shorter read zeroes the upper bytes.
        rdq.push_back(8'hEE);
        @(negedge clk);
        bus_address = 16'h0062; bus_datasize = 3'd1; bus_read = 1'b1;
        @(negedge clk);
        bus_read = 1'b0;
        wait_ready("rd62_done");
        chk("rd62_data", bus_readdata, 32'h0000_00EE);

        // Reset in the middle of a read, then a late ack.
        ack_en = 1'b0;
        base = n_log0;
        rdq.push_back(8'h99);
        @(negedge clk);
        bus_address = 16'h0063; bus_datasize = 3'd1; bus_read = 1'b1;
        @(negedge clk);
        bus_read = 1'b0;
        wait_log0(base + 1);
        @(negedge clk);
        chk("pre_rst_addr", 32'(dev_addr), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_io_wait",  32'(io_wait),   32'd0);
        chk("mid_rst_dev_req",  32'(dev_req),   32'd0);
        chk("mid_rst_dev_we",   32'(dev_we),    32'd0);
        chk("mid_rst_dev_addr", 32'(dev_addr),  32'd0);
        chk("mid_rst_wdata",    32'(dev_wdata), 32'd0);
        chk("mid_rst_readdata", bus_readdata,   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ack_en  = 1'b1;
        repeat (4) @(negedge clk);
        chk("late_ack_wait",     32'(io_wait),  32'd0);
        chk("late_ack_dev_req",  32'(dev_req),  32'd0);
        chk("late_ack_readdata", bus_readdata,  32'd0);
        chk("late_ack_no_req",   32'(n_log0),   32'(base + 1));

        base = n_log0;
        @(negedge clk);
        bus_address = 16'h0062; bus_datasize = 3'd1; bus_writedata = 32'h0000_005C; bus_write = 1'b1;
        @(negedge clk);
        bus_write = 1'b0;
        wait_log0(base + 1);
        chk("post_rst_addr", 32'(log_addr0[base]), 32'd2);
        chk("post_rst_data", 32'(log_data0[base]), 32'h0000_005C);

        // 32-bit aligned write on the IO32 instance.
        base1 = n_log1;
        w32   = 32'h1122_3344;
        @(negedge clk);
        bus_address = 16'h0064; bus_datasize = 3'd4; bus_writedata = w32; b1_write = 1'b1;
        #1;
        chk("w64_io32",      32'(b1_io32),  32'd1);
        chk("w64_wait",      32'(b1_wait),  32'd0);
        chk("w64_io32_byte", 32'(bus_io32), 32'd0);
        @(negedge clk);
        b1_write = 1'b0; bus_address = 16'h0065;
        #1 chk("a65_io32", 32'(b1_io32), 32'd0);
        begin
            int c;
            c = 0;
            while (n_log1 < base1 + 4 && c < 100) begin
                @(negedge clk);
                c++;
            end
        end
        chk("w64_count", 32'(n_log1), 32'(base1 + 4));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("w64_addr%0d", i), 32'(log_addr1[base1+i]), 32'd4 + 32'(i));
            chk($sformatf("w64_data%0d", i), 32'(log_data1[base1+i]), (w32 >> (8 * i)) & 32'hFF);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_target.md
IO_TARGET -- requirements
Module: io_target

Interface
REQ-001 Parameter BASE, 16'h0000, first I/O port decoded.
REQ-002 Parameter SPAN_LOG2, 3, decoded window is 2**SPAN_LOG2 ports starting at BASE.
REQ-003 Parameter IO32, 0, 1 = window accepts 32-bit single-pulse accesses.
REQ-004 Parameter WB_DEPTH, 4, posted write buffer entries (power of 2).
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 bus_address  in  16  port address from initiator.
REQ-008 bus_read / bus_write  in  1 each  single-cycle access strobes.
REQ-009 bus_datasize  in  3  bytes remaining in the transfer (1..4).
REQ-010 bus_writedata  in  32  write data, LSB = current byte.
REQ-011 bus_readdata  out  32  read data, LSB first, unused bytes zero.
REQ-012 bus_io32  out  1  combinational: hit & IO32 & bus_address[1:0]==0.
REQ-013 io_wait  out  1  stall to initiator.
REQ-014 dev_req  out  1  one-cycle device access request.
REQ-015 dev_we  out  1  request is a write.
REQ-016 dev_addr  out  SPAN_LOG2  port offset from BASE.
REQ-017 dev_wdata  out  8  device write byte.
REQ-018 dev_rdata  in  8  device read byte, valid with dev_ack.
REQ-019 dev_ack  in  1  one-cycle completion, at least 1 cycle after dev_req.

Function
REQ-020 Hit = bus_address in [BASE, BASE+2**SPAN_LOG2-1]; non-hit strobes are ignored, with no effect on io_wait, bus_io32 or bus_readdata.
REQ-021 Write hit with buffer not full: enqueue {offset, data, n} in the strobe cycle; n=4 if bus_io32, else 1; io_wait stays 0.
REQ-022 Write hit with buffer full: io_wait=1 combinationally in the strobe cycle; capture address, bus_datasize and bus_writedata into a hold register.
REQ-023 The held write is enqueued with n=4 if IO32-aligned, else n=held datasize, on the first cycle an entry is free; io_wait drops in the following cycle.
REQ-024 Read hit: register io_wait=1 at the sampling edge; the read is valid in the next cycle.
REQ-025 Read proceeds only after the write buffer has drained (strict ordering).
REQ-026 Read fetches n bytes: 4 if bus_io32, else bus_datasize; bytes are packed into bus_readdata[8k+7:8k]; bytes above n are zeroed.
REQ-027 bus_readdata is loaded in the same cycle io_wait falls and holds until the next read hit.
REQ-028 Device FSM states: IDLE, WR_REQ, WR_ACK, RD_REQ, RD_ACK, RD_DONE.
REQ-029 IDLE: a pending read with empty buffer goes to RD_REQ; otherwise a non-empty buffer goes to WR_REQ; otherwise stay in IDLE.
REQ-030 WR_REQ: pulse dev_req with dev_we=1 for byte k at offset+k, then go to WR_ACK; on ack, k++; when k==n, pop the entry and return to IDLE.
REQ-031 RD_REQ/RD_ACK: same sequencing with dev_we=0, capturing dev_rdata on ack; after the last byte go to RD_DONE, which clears io_wait and returns to IDLE.
REQ-032 Offset+k wraps modulo 2**SPAN_LOG2.
REQ-033 Simultaneous enqueue and pop in one cycle are both performed; the count is unchanged.
REQ-034 A strobe arriving while io_wait=1 is a protocol error; it is ignored.

Reset
REQ-035 Asserting reset_n low at any time, including mid-sequence, SHALL force: FSM IDLE, buffer empty, hold register invalid, io_wait 0, dev_req 0, dev_we 0, dev_addr 0, dev_wdata 0, bus_readdata 0.
REQ-036 A dev_ack arriving after reset release with no request outstanding SHALL be ignored.

Structure
REQ-037 A shared package SHALL define the FSM state encoding and the write-buffer entry typedef {offset, data[31:0], n[2:0]}.
REQ-038 The write buffer SHALL be a sub-module, io_target_wbuf (synchronous FIFO with full/empty flags and a count).

Verification
REQ-039 BASE=0x60: byte write 0x60 data 0xA5 -> io_wait 0; dev write off 0, data 0xA5.
REQ-040 IO32=1: 32-bit write 0x64 data 0x11223344 -> bus_io32 1; dev writes 44,33,22,11 to offsets 4,5,6,7.
REQ-041 Five byte writes with dev_ack held off -> fifth strobe sees io_wait 1; all 5 device writes occur in order.
REQ-042 Write 0x61 then read 0x61 size 2, device returns 0x5A, 0x3C -> read follows the write; bus_readdata 0x00003C5A when io_wait falls.
REQ-043 Read 0x67 size 2 -> dev offsets 7 then 0 (wrap).
REQ-044 reset_n low during RD_ACK -> all outputs at reset values; a late dev_ack has no effect.
